stack_arb: RTL and testbench
============================

STACK_ARB -- requirements
Module: stack_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of stack entries and data ports; SHALL be even.
REQ-002 Parameter STACK_SIZE, default 3: stack depth tracked by the level counter.
REQ-003 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Ports req0_valid / req1_valid  input  1: requester N presents a command.
REQ-006 Ports req0_op / req1_op  input  2: 00 POP, 01 PUSH_HALF, 10 PUSH_FULL, 11 PUSH_SPLIT.
REQ-007 Ports req0_data / req1_data  input  DATA_WIDTH: push operand.
REQ-008 Ports req0_ready / req1_ready  output  1: command accepted this cycle (valid&ready = handshake).
REQ-009 Port sm_valid  output  1: a command is issued to the stack datapath this cycle.
REQ-010 Port sm_ctl  output  2: op code of the issued command; 00 when sm_valid=0.
REQ-011 Port sm_data_in  output  DATA_WIDTH: operand of the issued command; 0 when sm_valid=0.
REQ-012 Port sm_data_out  input  DATA_WIDTH: popped value from the datapath, valid one cycle after a POP issue.
REQ-013 Port sm_wait  input  1: datapath busy; no issue while high.
REQ-014 Ports rsp_valid / rsp_id / rsp_err  output  1/1/1: completion strobe, requester index, rejected-command flag.
REQ-015 Port rsp_data  output  DATA_WIDTH: popped value; 0 unless rsp_valid with a successful POP.
REQ-016 Port level  output  2: current stack occupancy, 0..STACK_SIZE.

Function
REQ-017 At most one handshake per cycle; ready SHALL be asserted to at most one requester, and only when sm_wait=0 and no response is pending for that cycle's issue slot.
REQ-018 Arbitration SHALL be round-robin: priority pointer starts at requester 0 and moves to the other requester after every accepted command; a lone valid requester SHALL be granted irrespective of the pointer.
REQ-019 Entry count per op: POP -1, PUSH_HALF +1, PUSH_FULL +1, PUSH_SPLIT +2.
REQ-020 Legality: POP illegal when level=0; push illegal when level+count > STACK_SIZE.
REQ-021 Legal command: sm_valid=1 in the handshake cycle (combinational from grant); level updates at the following edge.
REQ-022 Illegal command: still handshaken, sm_valid=0, level unchanged; rsp_valid=1, rsp_err=1, rsp_data=0 one cycle later.
REQ-023 Operand formatting: PUSH_HALF sends zero-extended low DATA_WIDTH/2 bits; PUSH_FULL sends data unchanged; PUSH_SPLIT sends full data, datapath stores low half then high half (high half on top).
REQ-024 Legal push: rsp_valid=1, rsp_err=0, rsp_data=0 one cycle after handshake.
REQ-025 Legal POP: rsp_valid=1, rsp_err=0, rsp_data=sm_data_out exactly one cycle after handshake.
REQ-026 rsp_id SHALL equal the index of the requester handshaken in the previous cycle; all rsp_* fields SHALL be 0 when rsp_valid=0.
REQ-027 sm_wait high SHALL deassert both readies and sm_valid in the same cycle; pending responses still complete.
REQ-028 A requester held valid without ready SHALL keep its command; arbiter SHALL not drop or reorder a requester's own commands.
REQ-029 Back-to-back issue SHALL be allowed every cycle (throughput 1 command/cycle).

Reset
REQ-030 In a cycle with rst=1 at the edge: level=0, priority pointer=0, rsp_valid/rsp_id/rsp_err=0, rsp_data=0; readies and sm_valid SHALL be 0 while rst=1.
REQ-031 Reset mid-operation SHALL discard any pending response; no rsp_valid in the cycle after reset release.

Structure
REQ-032 Op codes (POP, PUSH_HALF, PUSH_FULL, PUSH_SPLIT) and per-op entry counts SHALL live in shared package stack_pkg.
REQ-033 Round-robin grant logic SHALL be sub-module rr_arb2 (2 requests, pointer, grant, advance).

Verification
REQ-034 Reset, req0 PUSH_FULL 0x12345678 -> sm_valid=1, sm_ctl=10, sm_data_in=0x12345678; next cycle level=1, rsp_valid=1, rsp_id=0, rsp_err=0.
REQ-035 Level=0, req1 POP -> sm_valid=0, next cycle rsp_err=1, rsp_id=1, level stays 0.
REQ-036 Level=2, req0 PUSH_SPLIT 0xAAAA5555 -> rsp_err=1, level 2; then PUSH_HALF 0xFFFF1234 -> sm_data_in=0x00001234, level 3.
REQ-037 Both requesters valid with PUSH_HALF for 4 cycles from level 0 -> grants 0,1,0 then 4th (req1) rejected with rsp_err=1; level=3.
REQ-038 Level=1, sm_wait=1 for 3 cycles with req0 POP held -> no ready, no sm_valid; on release POP issued, rsp_data=sm_data_out next cycle, level=0.
REQ-039 rst asserted the cycle after a legal POP handshake -> no rsp_valid afterwards, level=0.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared op codes and per-op entry counts for the stack arbiter.
package stack_pkg;

    // Command op codes as they appear on reqN_op and sm_ctl.
    typedef enum logic [1:0] {
        OpPop       = 2'b00,
        OpPushHalf  = 2'b01,
        OpPushFull  = 2'b10,
        OpPushSplit = 2'b11
    } stack_op_e;

    // Number of stack entries each op moves (POP removes, pushes add).
    localparam logic [1:0] CntPop       = 2'd1;
    localparam logic [1:0] CntPushHalf  = 2'd1;
    localparam logic [1:0] CntPushFull  = 2'd1;
    localparam logic [1:0] CntPushSplit = 2'd2;

    // Magnitude of the level change caused by an op.
    function automatic logic [1:0] op_count(stack_op_e op);
        logic [1:0] cnt;
        unique case (op)
            OpPop:       cnt = CntPop;
            OpPushHalf:  cnt = CntPushHalf;
            OpPushFull:  cnt = CntPushFull;
            OpPushSplit: cnt = CntPushSplit;
        endcase
        return cnt;
    endfunction

    // True for the only op that shrinks the stack.
    function automatic logic op_is_pop(stack_op_e op);
        return op == OpPop;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone request always wins; on contention the
// pointer picks the winner. The pointer toggles whenever a grant is accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    // Grant: pass a single request straight through, pointer breaks ties.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // Pointer next state: move to the other requester after each acceptance.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = ~ptr_q;
        end
    end

    // Pointer register with synchronous reset to requester 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stack_arb.sv
// Two-requester front end for a stack datapath. Arbitrates commands, checks
// them against the tracked occupancy, issues legal ones to the datapath and
// returns a one-cycle-later completion for every accepted command.
module stack_arb
    import stack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,  // must be even
    parameter int unsigned STACK_SIZE = 3    // must fit the 2-bit level port
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [1:0]            req0_op,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [1:0]            req1_op,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  sm_valid,
    output logic [1:0]            sm_ctl,
    output logic [DATA_WIDTH-1:0] sm_data_in,
    input  logic [DATA_WIDTH-1:0] sm_data_out,
    input  logic                  sm_wait,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            level
);

    localparam int unsigned HalfW      = DATA_WIDTH / 2;
    localparam logic [3:0]  StackSizeW = 4'(STACK_SIZE);

    logic                  issue_en;
    logic [1:0]            arb_req;
    logic [1:0]            grant;
    logic                  hs;
    logic                  sel;
    stack_op_e             sel_op;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [1:0]            sel_cnt;
    logic                  sel_pop;
    logic                  legal;

    logic [1:0] level_q,     level_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_id_q,    rsp_id_d;
    logic       rsp_err_q,   rsp_err_d;
    logic       rsp_pop_q,   rsp_pop_d;

    // Issue slot is open unless in reset or the datapath is stalling.
    // The response stage is a single register drained every cycle, so it
    // never blocks a new issue.
    assign issue_en = ~rst & ~sm_wait;
    assign arb_req  = issue_en ? {req1_valid, req0_valid} : 2'b00;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (hs),
        .grant   (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Select the granted command and decide whether the stack can take it.
    always_comb begin
        hs       = |grant;
        sel      = grant[1];
        sel_op   = stack_op_e'(sel ? req1_op : req0_op);
        sel_data = sel ? req1_data : req0_data;
        sel_cnt  = op_count(sel_op);
        sel_pop  = op_is_pop(sel_op);
        if (sel_pop) begin
            legal = (level_q != 2'd0);
        end else begin
            legal = ({2'b00, level_q} + {2'b00, sel_cnt}) <= StackSizeW;
        end
    end

    // Datapath command: only legal handshakes reach the stack; fields idle at 0.
    always_comb begin
        sm_valid   = hs & legal;
        sm_ctl     = 2'b00;
        sm_data_in = '0;
        if (sm_valid) begin
            sm_ctl = sel_op;
            unique case (sel_op)
                OpPop:       sm_data_in = '0;
                OpPushHalf:  sm_data_in = {{HalfW{1'b0}}, sel_data[HalfW-1:0]};
                // The datapath splits a PUSH_SPLIT operand itself.
                OpPushFull:  sm_data_in = sel_data;
                OpPushSplit: sm_data_in = sel_data;
            endcase
        end
    end

    // Occupancy and response next state.
    always_comb begin
        level_d = level_q;
        if (sm_valid) begin
            level_d = sel_pop ? (level_q - sel_cnt) : (level_q + sel_cnt);
        end
        rsp_valid_d = hs;
        rsp_id_d    = sel;
        rsp_err_d   = hs & ~legal;
        rsp_pop_d   = sm_valid & sel_pop;
    end

    // State registers; reset also discards any in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q     <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_pop_q   <= 1'b0;
        end else begin
            level_q     <= level_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_pop_q   <= rsp_pop_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    // Popped value arrives from the datapath in the response cycle.
    assign rsp_data  = rsp_pop_q ? sm_data_out : '0;
    assign level     = level_q;

endmodule

// File: tb/tb_stack_arb.sv
// Bench for stack_arb: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the arbiter and occupancy rules.
module tb_stack_arb;

    localparam int DW = 32;
    localparam int SS = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0]    req0_op = 2'b00, req1_op = 2'b00;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready;
    logic          sm_valid;
    logic [1:0]    sm_ctl;
    logic [DW-1:0] sm_data_in;
    logic [DW-1:0] sm_data_out = '0;
    logic          sm_wait = 1'b0;
    logic          rsp_valid, rsp_id, rsp_err;
    logic [DW-1:0] rsp_data;
    logic [1:0]    level;

    int checks = 0;
    int failures = 0;

    stack_arb #(.DATA_WIDTH(DW), .STACK_SIZE(SS)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_op     (req0_op),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_op     (req1_op),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .sm_valid    (sm_valid),
        .sm_ctl      (sm_ctl),
        .sm_data_in  (sm_data_in),
        .sm_data_out (sm_data_out),
        .sm_wait     (sm_wait),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_err     (rsp_err),
        .rsp_data    (rsp_data),
        .level       (level)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit          hs;
        bit          sel;
        bit          legal;
        bit          is_pop;
        int          cnt;
        bit          rdy0;
        bit          rdy1;
        bit          smv;
        logic [1:0]  ctl;
        logic [31:0] din;
    } exp_t;

    int m_level = 0;
    bit m_ptr = 0;
    bit m_rv = 0, m_rid = 0, m_rerr = 0, m_rpop = 0;

    function automatic exp_t model_comb();
        exp_t e;
        logic [1:0]  op;
        logic [31:0] d;
        e = '{default: 0};
        if (!rst && !sm_wait && (req0_valid || req1_valid)) begin
            e.hs  = 1;
            e.sel = (req0_valid && req1_valid) ? m_ptr : req1_valid;
        end
        op = e.sel ? req1_op : req0_op;
        d  = e.sel ? req1_data : req0_data;
        e.is_pop = (op == 2'b00);
        e.cnt    = e.is_pop ? -1 : ((op == 2'b11) ? 2 : 1);
        e.legal  = (m_level + e.cnt >= 0) && (m_level + e.cnt <= SS);
        e.rdy0   = e.hs && !e.sel;
        e.rdy1   = e.hs && e.sel;
        e.smv    = e.hs && e.legal;
        if (e.smv) begin
            e.ctl = op;
            if (op == 2'b01)      e.din = d % 32'd65536;
            else if (op == 2'b00) e.din = 0;
            else                  e.din = d;
        end
        return e;
    endfunction

    // Advance model state on each rising edge from the bench-driven inputs.
    always @(posedge clk) begin : model_seq
        exp_t e;
        e = model_comb();
        if (rst) begin
            m_level <= 0; m_ptr <= 0;
            m_rv <= 0; m_rid <= 0; m_rerr <= 0; m_rpop <= 0;
        end else begin
            m_rv   <= e.hs;
            m_rid  <= e.hs && e.sel;
            m_rerr <= e.hs && !e.legal;
            m_rpop <= e.smv && e.is_pop;
            if (e.smv) m_level <= m_level + e.cnt;
            if (e.hs)  m_ptr <= !m_ptr;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        req0_valid = 0; req1_valid = 0; sm_wait = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); idle(); rst = 1;
        @(negedge clk);
        @(negedge clk); rst = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk); rst = 1;
        req0_valid = 1; req0_op = 2'b10; req1_valid = 1; req1_op = 2'b01;
        #1;
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL rst_ready0 got=%b exp=0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL rst_ready1 got=%b exp=0", req1_ready); end
        checks++; if (sm_valid !== 1'b0) begin failures++; $display("FAIL rst_sm_valid got=%b exp=0", sm_valid); end
        @(negedge clk); #1;
        checks++; if (level !== 2'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", level); end
        checks++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b000) begin failures++; $display("FAIL rst_rsp got=%b exp=000", {rsp_valid, rsp_id, rsp_err}); end
        checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL rst_rsp_data got=%h exp=0", rsp_data); end
        @(negedge clk); rst = 0; idle(); #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_release_rsp got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_push_full();
        do_reset();
        req0_valid = 1; req0_op = 2'b10; req0_data = 32'h12345678; #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL pf_ready got=%b exp=1", req0_ready); end
        checks++; if (sm_valid !== 1'b1) begin failures++; $display("FAIL pf_sm_valid got=%b exp=1", sm_valid); end
        checks++; if (sm_ctl !== 2'b10) begin failures++; $display("FAIL pf_sm_ctl got=%b exp=10", sm_ctl); end
        checks++; if (sm_data_in !== 32'h12345678) begin failures++; $display("FAIL pf_sm_data_in got=%h exp=12345678", sm_data_in); end
        @(negedge clk); idle(); #1;
        checks++; if (level !== 2'd1) begin failures++; $display("FAIL pf_level got=%0d exp=1", level); end
        checks++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b100) begin failures++; $display("FAIL pf_rsp got=%b exp=100", {rsp_valid, rsp_id, rsp_err}); end
        checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL pf_rsp_data got=%h exp=0", rsp_data); end
    endtask

    task automatic test_pop_empty();
        do_reset();
        req1_valid = 1; req1_op = 2'b00; #1;
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL pe_ready got=%b exp=1", req1_ready); end
        checks++; if (sm_valid !== 1'b0) begin failures++; $display("FAIL pe_sm_valid got=%b exp=0", sm_valid); end
        @(negedge clk); idle(); sm_data_out = 32'h5A5A5A5A; #1;
        checks++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b111) begin failures++; $display("FAIL pe_rsp got=%b exp=111", {rsp_valid, rsp_id, rsp_err}); end
        checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL pe_rsp_data got=%h exp=0", rsp_data); end
        checks++; if (level !== 2'd0) begin failures++; $display("FAIL pe_level got=%0d exp=0", level); end
    endtask

    task automatic test_split_overflow();
        do_reset();
        req0_valid = 1; req0_op = 2'b01; req0_data = 32'h1;
        @(negedge clk); req0_data = 32'h2;
        @(negedge clk); req0_op = 2'b11; req0_data = 32'hAAAA5555; #1;
        checks++; if (level !== 2'd2) begin failures++; $display("FAIL sp_level_pre got=%0d exp=2", level); end
        checks++; if (sm_valid !== 1'b0) begin failures++; $display("FAIL sp_sm_valid got=%b exp=0", sm_valid); end
        @(negedge clk); req0_op = 2'b01; req0_data = 32'hFFFF1234; #1;
        checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL sp_rsp_err got=%b exp=1", rsp_err); end
        checks++; if (level !== 2'd2) begin failures++; $display("FAIL sp_level_hold got=%0d exp=2", level); end
        checks++; if (sm_data_in !== 32'h00001234) begin failures++; $display("FAIL sp_half_data got=%h exp=00001234", sm_data_in); end
        @(negedge clk); idle(); #1;
        checks++; if (level !== 2'd3) begin failures++; $display("FAIL sp_level_full got=%0d exp=3", level); end
        checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL sp_rsp_ok got=%b exp=0", rsp_err); end
    endtask

    task automatic test_round_robin();
        bit          exp_g[4]   = '{0, 1, 0, 1};
        bit          exp_v[4]   = '{1, 1, 1, 0};
        logic [31:0] exp_din[4] = '{32'h1, 32'h2, 32'h3, 32'h0};
        do_reset();
        req0_valid = 1; req1_valid = 1; req0_op = 2'b01; req1_op = 2'b01;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            req0_data = (k < 1) ? 32'h11110001 : 32'h11110003;
            req1_data = (k < 2) ? 32'h22220002 : 32'h22220004;
            #1;
            checks++; if ({req1_ready, req0_ready} !== (exp_g[k] ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp_idx=%0d", k, {req1_ready, req0_ready}, exp_g[k]); end
            checks++; if (sm_valid !== exp_v[k]) begin failures++; $display("FAIL rr_sm_valid k=%0d got=%b exp=%b", k, sm_valid, exp_v[k]); end
            checks++; if (sm_data_in !== exp_din[k]) begin failures++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, sm_data_in, exp_din[k]); end
        end
        @(negedge clk); idle(); #1;
        checks++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b111) begin failures++; $display("FAIL rr_rsp got=%b exp=111", {rsp_valid, rsp_id, rsp_err}); end
        checks++; if (level !== 2'd3) begin failures++; $display("FAIL rr_level got=%0d exp=3", level); end
    endtask

    task automatic test_wait_stall();
        do_reset();
        req0_valid = 1; req0_op = 2'b10; req0_data = 32'h11;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); req0_op = 2'b00; sm_wait = 1; #1;
            checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL wt_ready k=%0d got=%b exp=0", k, req0_ready); end
            checks++; if (sm_valid !== 1'b0) begin failures++; $display("FAIL wt_sm_valid k=%0d got=%b exp=0", k, sm_valid); end
            checks++; if (rsp_valid !== (k == 0)) begin failures++; $display("FAIL wt_rsp k=%0d got=%b exp=%b", k, rsp_valid, k == 0); end
        end
        @(negedge clk); sm_wait = 0; #1;
        checks++; if ({req0_ready, sm_valid, sm_ctl} !== 4'b1100) begin failures++; $display("FAIL wt_issue got=%b exp=1100", {req0_ready, sm_valid, sm_ctl}); end
        @(negedge clk); idle(); sm_data_out = 32'hDEADBEEF; #1;
        checks++; if (rsp_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wt_rsp_data got=%h exp=deadbeef", rsp_data); end
        checks++; if (level !== 2'd0) begin failures++; $display("FAIL wt_level got=%0d exp=0", level); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0_valid = 1; req0_op = 2'b01; req0_data = 32'h5;
        @(negedge clk); req0_op = 2'b00;
        @(negedge clk); idle(); rst = 1; sm_data_out = 32'hCAFEF00D;
        @(negedge clk); rst = 0; #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_rsp got=%b exp=0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin failures++; $display("FAIL rm_rsp_data got=%h exp=0", rsp_data); end
        checks++; if (level !== 2'd0) begin failures++; $display("FAIL rm_level got=%0d exp=0", level); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_rsp_after got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_random_traffic();
        bit          hs0 = 0, hs1 = 0;
        exp_t        e;
        logic [31:0] exp_rd;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            // A command is held until accepted; only then may it change.
            if (!req0_valid || hs0) begin
                req0_valid = ($urandom_range(99) < 70);
                req0_op = 2'($urandom_range(3)); req0_data = $urandom();
            end
            if (!req1_valid || hs1) begin
                req1_valid = ($urandom_range(99) < 70);
                req1_op = 2'($urandom_range(3)); req1_data = $urandom();
            end
            sm_wait = ($urandom_range(99) < 20);
            rst = ($urandom_range(99) < 2);
            sm_data_out = $urandom();
            #1;
            e = model_comb();
            exp_rd = m_rpop ? sm_data_out : 32'h0;
            checks++; if (req0_ready !== e.rdy0) begin failures++; $display("FAIL rnd_ready0 c=%0d got=%b exp=%b", c, req0_ready, e.rdy0); end
            checks++; if (req1_ready !== e.rdy1) begin failures++; $display("FAIL rnd_ready1 c=%0d got=%b exp=%b", c, req1_ready, e.rdy1); end
            checks++; if (sm_valid !== e.smv) begin failures++; $display("FAIL rnd_sm_valid c=%0d got=%b exp=%b", c, sm_valid, e.smv); end
            checks++; if (sm_ctl !== e.ctl) begin failures++; $display("FAIL rnd_sm_ctl c=%0d got=%b exp=%b", c, sm_ctl, e.ctl); end
            checks++; if (sm_data_in !== e.din) begin failures++; $display("FAIL rnd_sm_data c=%0d got=%h exp=%h", c, sm_data_in, e.din); end
            checks++; if (rsp_valid !== m_rv) begin failures++; $display("FAIL rnd_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, m_rv); end
            checks++; if (rsp_id !== m_rid) begin failures++; $display("FAIL rnd_rsp_id c=%0d got=%b exp=%b", c, rsp_id, m_rid); end
            checks++; if (rsp_err !== m_rerr) begin failures++; $display("FAIL rnd_rsp_err c=%0d got=%b exp=%b", c, rsp_err, m_rerr); end
            checks++; if (rsp_data !== exp_rd) begin failures++; $display("FAIL rnd_rsp_data c=%0d got=%h exp=%h", c, rsp_data, exp_rd); end
            checks++; if (level !== 2'(m_level)) begin failures++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, m_level); end
            hs0 = e.rdy0; hs1 = e.rdy1;
        end
        @(negedge clk); idle(); rst = 0;
    endtask

    initial begin
        test_reset();
        test_push_full();
        test_pop_empty();
        test_split_overflow();
        test_round_robin();
        test_wait_stall();
        test_reset_mid();
        test_random_traffic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
